// File: rtl/wb_bfm_pkg.sv
// Types and helpers shared by the Wishbone BFM initiator and responder cores.
package wb_bfm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        GAP    = 2'd2
    } wb_master_state_e;

    // Byte distance between consecutive beats of an incrementing burst.
    function automatic int unsigned beat_increment(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/wb_master_bfm_core_if.sv
// Command, response and Wishbone bus signals of the initiator core.
interface wb_master_bfm_core_if #(
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32,
    parameter int LEN_WIDTH     = 8
) ();

    logic                       cmd_valid;
    logic                       cmd_ready;
    logic                       cmd_we;
    logic [WB_ADDR_WIDTH-1:0]   cmd_adr;
    logic [WB_DATA_WIDTH/8-1:0] cmd_sel;
    logic [WB_DATA_WIDTH-1:0]   cmd_dat;
    logic [LEN_WIDTH-1:0]       cmd_len;

    logic                       rsp_valid;
    logic [WB_DATA_WIDTH-1:0]   rsp_dat;
    logic                       rsp_err;
    logic                       rsp_last;

    logic                       CYC;
    logic                       STB;
    logic                       WE;
    logic [WB_ADDR_WIDTH-1:0]   ADR;
    logic [WB_DATA_WIDTH/8-1:0] SEL;
    logic [WB_DATA_WIDTH-1:0]   DAT_W;
    logic [WB_DATA_WIDTH-1:0]   DAT_R;
    logic                       ACK;
    logic                       ERR;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_sel, cmd_dat, cmd_len,
        output cmd_ready,
        output rsp_valid, rsp_dat, rsp_err, rsp_last,
        output CYC, STB, WE, ADR, SEL, DAT_W,
        input  DAT_R, ACK, ERR
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_sel, cmd_dat, cmd_len,
        input  cmd_ready,
        input  rsp_valid, rsp_dat, rsp_err, rsp_last,
        input  CYC, STB, WE, ADR, SEL, DAT_W,
        output DAT_R, ACK, ERR
    );

endinterface

// File: rtl/wb_bfm_watchdog.sv
// Saturating cycle counter that flags when TIMEOUT enabled cycles have elapsed.
module wb_bfm_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int            CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // A zero TIMEOUT disables the watchdog entirely.
    assign expired_o = (TIMEOUT != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/wb_master_bfm_core.sv
// Wishbone classic-cycle initiator: turns single/burst commands into bus beats
// and returns one response per beat.
module wb_master_bfm_core
    import wb_bfm_pkg::*;
#(
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32,
    parameter int LEN_WIDTH     = 8,
    parameter int TIMEOUT       = 1024
) (
    input logic                  clk,
    input logic                  rstn,
    wb_master_bfm_core_if.master bus
);

    localparam logic [WB_ADDR_WIDTH-1:0] ADR_STEP =
        WB_ADDR_WIDTH'(beat_increment(WB_DATA_WIDTH));

    wb_master_state_e           state_q;
    logic [LEN_WIDTH-1:0]       remaining_q;
    logic                       cmd_ready_q;
    logic                       cyc_q;
    logic                       stb_q;
    logic                       we_q;
    logic [WB_ADDR_WIDTH-1:0]   adr_q;
    logic [WB_ADDR_WIDTH-1:0]   adr_d;
    logic [WB_DATA_WIDTH/8-1:0] sel_q;
    logic [WB_DATA_WIDTH-1:0]   dat_w_q;
    logic                       rsp_valid_q;
    logic [WB_DATA_WIDTH-1:0]   rsp_dat_q;
    logic                       rsp_err_q;
    logic                       rsp_last_q;
    logic                       ack_d;
    logic                       abort_d;
    logic                       expired;

    wb_bfm_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rstn      (rstn),
        .clr_i     (state_q != STROBE),
        .en_i      (state_q == STROBE),
        .expired_o (expired)
    );

    // Undriven or unknown ACK/ERR count as deasserted; an expired watchdog aborts like ERR.
    assign ack_d   = (bus.ACK === 1'b1);
    assign abort_d = (bus.ERR === 1'b1) || expired;
    assign adr_d   = adr_q + ADR_STEP;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            cmd_ready_q <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            sel_q       <= '0;
            dat_w_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (bus.cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        we_q        <= bus.cmd_we;
                        adr_q       <= bus.cmd_adr;
                        sel_q       <= bus.cmd_sel;
                        dat_w_q     <= bus.cmd_dat;
                        remaining_q <= (bus.cmd_len == '0) ? LEN_WIDTH'(1) : bus.cmd_len;
                        cyc_q       <= 1'b1;
                        stb_q       <= 1'b1;
                        state_q     <= STROBE;
                    end
                end
                STROBE: begin
                    if (abort_d) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_last_q  <= 1'b1;
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end else if (ack_d) begin
                        rsp_valid_q <= 1'b1;
                        rsp_dat_q   <= we_q ? '0 : bus.DAT_R;
                        stb_q       <= 1'b0;
                        if (remaining_q == LEN_WIDTH'(1)) begin
                            rsp_last_q  <= 1'b1;
                            cyc_q       <= 1'b0;
                            cmd_ready_q <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            remaining_q <= remaining_q - 1'b1;
                            adr_q       <= adr_d;
                            state_q     <= GAP;
                        end
                    end
                end
                GAP: begin
                    stb_q   <= 1'b1;
                    state_q <= STROBE;
                end
                default: begin
                    cyc_q       <= 1'b0;
                    stb_q       <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.CYC       = cyc_q;
    assign bus.STB       = stb_q;
    assign bus.WE        = we_q;
    assign bus.ADR       = adr_q;
    assign bus.SEL       = sel_q;
    assign bus.DAT_W     = dat_w_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_dat   = rsp_dat_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_wb_master_bfm_core.sv
// Scoreboard bench for wb_master_bfm_core with a scripted slave and a beat-level reference model.
module tb_wb_master_bfm_core;

    localparam int TO     = 16;
    localparam int K_ACK  = 0;
    localparam int K_ERR  = 1;
    localparam int K_BOTH = 2;
    localparam int K_NONE = 3;

    typedef struct {
        int          kind;
        int          lat;
        logic [31:0] rdat;
        bit          last;
    } beat_t;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
    } busexp_t;

    typedef struct {
        logic [31:0] dat;
        logic        err;
        logic        last;
    } rsp_t;

    logic clk = 1'b0;
    logic rstn;

    wb_master_bfm_core_if #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .LEN_WIDTH(8)) bus ();

    wb_master_bfm_core #(
        .WB_ADDR_WIDTH (32),
        .WB_DATA_WIDTH (32),
        .LEN_WIDTH     (8),
        .TIMEOUT       (TO)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rsp_seen = 0;

    beat_t   plan_q[$];
    busexp_t bus_q[$];
    rsp_t    rsp_q[$];

    int          plan_kind [16];
    int          plan_lat  [16];
    logic [31:0] plan_dat  [16];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: derive every beat's bus view and response from the command and slave plan.
    task automatic send(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, input logic [7:0] len);
        int n;
        int w;
        logic [31:0] a;
        beat_t b;
        n = (len == 8'd0) ? 1 : int'(len);
        a = adr;
        for (int i = 0; i < n; i++) begin
            b.kind = plan_kind[i];
            b.lat  = plan_lat[i];
            b.rdat = plan_dat[i];
            b.last = (plan_kind[i] != K_ACK) || (i == n - 1);
            plan_q.push_back(b);
            bus_q.push_back('{a, we, sel, dat});
            if (plan_kind[i] != K_ACK) begin
                rsp_q.push_back('{32'h0, 1'b1, 1'b1});
                break;
            end
            rsp_q.push_back('{we ? 32'h0 : plan_dat[i], 1'b0, (i == n - 1)});
            a = a + 32'd4;
        end
        @(negedge clk);
        w = 0;
        while (bus.cmd_ready !== 1'b1 && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (w >= 500) begin
            checks++;
            errors++;
            $display("FAIL cmd_ready_wait: got timeout expected cmd_ready=1");
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_adr   = adr;
        bus.cmd_sel   = sel;
        bus.cmd_dat   = dat;
        bus.cmd_len   = len;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic set_plan(input int idx, input int kind, input int lat, input logic [31:0] d);
        plan_kind[idx] = kind;
        plan_lat[idx]  = lat;
        plan_dat[idx]  = d;
    endtask

    // Response monitor
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                rsp_seen++;
                if (rsp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got dat=%0h err=%0b last=%0b expected no response",
                             bus.rsp_dat, bus.rsp_err, bus.rsp_last);
                end else begin
                    e = rsp_q.pop_front();
                    chk("rsp{dat,err,last}", {30'h0, bus.rsp_dat, bus.rsp_err, bus.rsp_last},
                        {30'h0, e.dat, e.err, e.last});
                end
            end
        end
    end

    // Scripted slave: answers each STB according to the plan and checks bus fields and timing.
    initial begin
        bit      in_beat;
        int      wc;
        int      post;
        beat_t   cur;
        busexp_t eb;
        in_beat = 1'b0;
        wc = 0;
        post = 0;
        cur = '{K_ACK, 0, 32'h0, 1'b1};
        bus.ACK = 1'b0;
        bus.ERR = 1'b0;
        bus.DAT_R = '0;
        forever begin
            @(negedge clk);
            bus.ACK = 1'b0;
            bus.ERR = 1'b0;
            bus.DAT_R = $urandom;
            if (rstn !== 1'b1) begin
                in_beat = 1'b0;
                post = 0;
                continue;
            end
            if (post == 1)
                chk("gap{CYC,STB}", {bus.CYC, bus.STB}, 2'b10);
            else if (post == 2)
                chk("after_last{CYC,cmd_ready}", {bus.CYC, bus.cmd_ready}, 2'b01);
            post = 0;
            if (bus.CYC === 1'b1 && bus.STB === 1'b1) begin
                if (!in_beat) begin
                    in_beat = 1'b1;
                    wc = 0;
                    if (plan_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL stb_unexpected: got STB=1 ADR=%0h expected no beat", bus.ADR);
                        cur = '{K_ACK, 0, 32'h0, 1'b1};
                    end else begin
                        cur = plan_q.pop_front();
                        eb = bus_q.pop_front();
                        chk("beat_adr", {32'h0, bus.ADR}, {32'h0, eb.adr});
                        chk("beat{we,sel,dat_w}", {27'h0, bus.WE, bus.SEL, bus.DAT_W},
                            {27'h0, eb.we, eb.sel, eb.dat});
                    end
                end
                if (cur.kind != K_NONE && wc == cur.lat) begin
                    bus.ACK   = (cur.kind == K_ACK) || (cur.kind == K_BOTH);
                    bus.ERR   = (cur.kind == K_ERR) || (cur.kind == K_BOTH);
                    bus.DAT_R = cur.rdat;
                    in_beat = 1'b0;
                    post = cur.last ? 2 : 1;
                end else begin
                    wc++;
                end
            end else if (in_beat) begin
                in_beat = 1'b0;
                if (cur.kind == K_NONE) begin
                    chk("timeout_stb_cycles", 64'(wc), 64'(TO + 1));
                    chk("timeout{CYC,cmd_ready}", {bus.CYC, bus.cmd_ready}, 2'b01);
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL stb_dropped: got STB=0 after %0d cycles expected ACK/ERR at %0d",
                             wc, cur.lat);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int w;
        int seen0;
        int r;
        int len;
        rstn = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_we = 1'b0;
        bus.cmd_adr = '0;
        bus.cmd_sel = '0;
        bus.cmd_dat = '0;
        bus.cmd_len = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst{CYC,STB,WE}", {bus.CYC, bus.STB, bus.WE}, 3'b000);
        chk("rst_ADR", {32'h0, bus.ADR}, 64'h0);
        chk("rst{SEL,DAT_W}", {28'h0, bus.SEL, bus.DAT_W}, 64'h0);
        chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
        chk("rst{rsp_valid,err,last,dat}",
            {29'h0, bus.rsp_valid, bus.rsp_err, bus.rsp_last, bus.rsp_dat}, 64'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("cmd_ready_after_reset", bus.cmd_ready, 1'b1);

        // Single write, slave answering two edges after STB
        set_plan(0, K_ACK, 1, 32'h0BAD_F00D);
        send(1'b1, 32'h100, 4'hF, 32'hDEAD_BEEF, 8'd1);

        // Read burst of four
        set_plan(0, K_ACK, 1, 32'h11);
        set_plan(1, K_ACK, 1, 32'h22);
        set_plan(2, K_ACK, 1, 32'h33);
        set_plan(3, K_ACK, 1, 32'h44);
        send(1'b0, 32'h1000, 4'hF, 32'h0, 8'd4);

        // ERR on beat 2 of 3
        set_plan(0, K_ACK, 0, 32'h55);
        set_plan(1, K_ERR, 2, 32'h66);
        set_plan(2, K_ACK, 0, 32'h77);
        send(1'b0, 32'h2000, 4'h3, 32'h0, 8'd3);

        // Slave never answers
        set_plan(0, K_NONE, 0, 32'h0);
        send(1'b1, 32'h3000, 4'hF, 32'h1234_5678, 8'd1);

        // Address wraps at the top of the space
        set_plan(0, K_ACK, 0, 32'hAAAA_0001);
        set_plan(1, K_ACK, 0, 32'hAAAA_0002);
        send(1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0, 8'd2);

        // Zero length behaves as one beat
        set_plan(0, K_ACK, 0, 32'hC0DE_0000);
        send(1'b0, 32'h4000, 4'h1, 32'h0, 8'd0);

        // ACK and ERR together
        set_plan(0, K_BOTH, 1, 32'hFFFF_FFFF);
        send(1'b0, 32'h5000, 4'hF, 32'h0, 8'd1);

        // Back-to-back zero-wait singles
        for (int i = 0; i < 3; i++) begin
            set_plan(0, K_ACK, 0, $urandom);
            send(1'(i), 32'h6000 + 32'(i * 4), 4'hF, $urandom, 8'd1);
        end

        // Reset during beat 2 of a 4-beat read
        set_plan(0, K_ACK, 1, 32'hA5A5_0001);
        set_plan(1, K_NONE, 0, 32'h0);
        seen0 = rsp_seen;
        send(1'b0, 32'h7000, 4'hF, 32'h0, 8'd4);
        w = 0;
        while (rsp_seen == seen0 && w < 200) begin
            @(posedge clk);
            w++;
        end
        chk("rst_mid_beat1_seen", 64'(rsp_seen != seen0), 64'h1);
        @(negedge clk);
        chk("rst_mid_stb_before", bus.STB, 1'b1);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid{CYC,STB,cmd_ready,rsp_valid}",
            {bus.CYC, bus.STB, bus.cmd_ready, bus.rsp_valid}, 4'b0000);
        @(negedge clk);
        rsp_q.delete();
        plan_q.delete();
        bus_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_cmd_ready", bus.cmd_ready, 1'b1);
        repeat (4) @(posedge clk);

        // Randomised commands
        for (int c = 0; c < 60; c++) begin
            len = $urandom_range(0, 6);
            for (int i = 0; i < 16; i++) begin
                r = $urandom_range(0, 99);
                set_plan(i, (r < 88) ? K_ACK : (r < 94) ? K_ERR : (r < 98) ? K_BOTH : K_NONE,
                         $urandom_range(0, 3), $urandom);
            end
            if ($urandom_range(0, 7) == 0)
                send(1'($urandom), 32'hFFFF_FFF0 + ($urandom & 32'h0000_000C), 4'($urandom),
                     $urandom, 8'(len));
            else
                send(1'($urandom), $urandom & 32'hFFFF_FFFC, 4'($urandom), $urandom, 8'(len));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        w = 0;
        while ((rsp_q.size() != 0 || plan_q.size() != 0) && w < 3000) begin
            @(posedge clk);
            w++;
        end
        repeat (5) @(posedge clk);
        chk("drain{rsp_q,plan_q,bus_q}",
            {32'(rsp_q.size()), 16'(plan_q.size()), 16'(bus_q.size())}, 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
